// File: rtl/l0mdt_dataformats_svh.sv
// MTC2SL word layout shared by the sector-logic blocks.
// Field positions only; consumers slice, never redefine.
package l0mdt_dataformats_svh;

  localparam int MTC2SL_LEN = 48;
  localparam int SLC_COMMON_LEN = 27;
  localparam int MTC2SL_COMMON_LSB = 20;
  localparam int MTC2SL_MDT_PROCFLAGS_LSB = 0;
  localparam int MTC2SL_MDT_PROCFLAGS_MSB = 3;

endpackage

// File: rtl/mtc_rx_pkg.sv
// Shared types and constants for the MTC2SL receiver.
// Field layout is taken from l0mdt_dataformats_svh.
package mtc_rx_pkg;

  import l0mdt_dataformats_svh::*;

  localparam int MTC_RX_PKT_LEN = MTC2SL_LEN - 1;
  localparam int MTC_RX_N_MAX = 8;
  localparam int MTC_RX_PF_W =
    MTC2SL_MDT_PROCFLAGS_MSB - MTC2SL_MDT_PROCFLAGS_LSB + 1;

  typedef logic [$clog2(MTC_RX_N_MAX)-1:0] mtc_rx_lane_t;
  typedef logic [MTC_RX_PF_W-1:0] mtc_rx_pf_t;

  localparam mtc_rx_pf_t PF_PASS = 4'd1;
  localparam mtc_rx_pf_t PF_FAIL = 4'd2;
  localparam mtc_rx_pf_t PF_NOSEG = 4'd4;
  localparam mtc_rx_pf_t PF_INVALID = 4'hf;

endpackage

// File: rtl/mtc_rx_lane_buf.sv
// Two-entry per-lane skid FIFO for the MTC2SL receiver.
// drop pulses when a push meets a full buffer with no pop.
module mtc_rx_lane_buf
  import mtc_rx_pkg::*;
#(
  parameter int W = MTC_RX_PKT_LEN
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  logic [W-1:0] tail;
  logic [1:0]   count;
  logic         do_pop;

  assign full   = (count == 2'd2);
  assign empty  = (count == 2'd0);
  assign do_pop = pop && !empty;
  assign drop   = push && full && !do_pop;

  always_ff @(posedge clock) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      unique case ({push, do_pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else if (count == 2'd1) tail <= push_data;
          if (!full) count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; new word goes behind the survivor
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mtc_pkt_receiver.sv
// MTC2SL receiver: per-lane skid buffers, round-robin serialiser, decode.
// Define MTC_RX_PROCFLAG_STATS_EN to build the procflag statistics counters.
module mtc_pkt_receiver
  import l0mdt_dataformats_svh::*;
  import mtc_rx_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int DROP_CNT_W = 16,
  parameter int STAT_CNT_W = 32,
  localparam int LW = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic [MTC2SL_LEN-1:0]     mtc_in [N_IN],
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MTC_RX_PKT_LEN-1:0] out_pkt,
  output logic [SLC_COMMON_LEN-1:0] out_common,
  output logic [MTC_RX_PF_W-1:0]    out_procflags,
  output logic [LW-1:0]             out_lane,
  output logic [DROP_CNT_W-1:0]     drop_cnt [N_IN],
  input  logic                      stats_clr,
  output logic [STAT_CNT_W-1:0]     stat_pass,
  output logic [STAT_CNT_W-1:0]     stat_fail,
  output logic [STAT_CNT_W-1:0]     stat_other
);

  logic [MTC_RX_PKT_LEN-1:0] head [N_IN];
  logic [N_IN-1:0] full;
  logic [N_IN-1:0] empty;
  logic [N_IN-1:0] drop;
  logic [N_IN-1:0] pop;

  for (genvar i = 0; i < N_IN; i++) begin : g_lane
    mtc_rx_lane_buf #(.W(MTC_RX_PKT_LEN)) u_buf (
      .clock     (clock),
      .rst       (rst),
      .push      (mtc_in[i][MTC2SL_LEN-1]),
      .push_data (mtc_in[i][MTC_RX_PKT_LEN-1:0]),
      .pop       (pop[i]),
      .head      (head[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .drop      (drop[i])
    );

    always_ff @(posedge clock) begin
      if (rst || stats_clr) drop_cnt[i] <= '0;
      else if (drop[i] && !(&drop_cnt[i]))
        drop_cnt[i] <= drop_cnt[i] + 1'b1;
    end
  end

  mtc_rx_lane_t ptr;
  mtc_rx_lane_t gnt;
  logic any;
  logic free;
  logic [MTC_RX_PKT_LEN-1:0] sel;
  int idx;

  assign free = !out_valid || out_ready;

  always_comb begin
    any = 1'b0;
    gnt = '0;
    idx = 0;
    for (int j = 0; j < N_IN; j++) begin
      idx = (int'(ptr) + j) % N_IN;
      if (!any && !empty[idx]) begin
        any = 1'b1;
        gnt = mtc_rx_lane_t'(idx);
      end
    end
  end

  assign sel = head[gnt];

  always_comb begin
    pop = '0;
    if (free && any) pop[gnt] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_pkt       <= '0;
      out_common    <= '0;
      out_procflags <= '0;
      out_lane      <= '0;
      ptr           <= '0;
    end else if (free) begin
      out_valid <= any;
      if (any) begin
        out_pkt       <= sel;
        out_common    <= sel[MTC2SL_COMMON_LSB +: SLC_COMMON_LEN];
        out_procflags <= sel[MTC2SL_MDT_PROCFLAGS_MSB:
                             MTC2SL_MDT_PROCFLAGS_LSB];
        out_lane      <= LW'(gnt);
        ptr <= mtc_rx_lane_t'((int'(gnt) + 1) % N_IN);
      end
    end
  end

`ifdef MTC_RX_PROCFLAG_STATS_EN
  logic hs;
  assign hs = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (rst || stats_clr) begin
      stat_pass  <= '0;
      stat_fail  <= '0;
      stat_other <= '0;
    end else if (hs) begin
      if (out_procflags == PF_PASS) begin
        if (!(&stat_pass)) stat_pass <= stat_pass + 1'b1;
      end else if (out_procflags == PF_FAIL) begin
        if (!(&stat_fail)) stat_fail <= stat_fail + 1'b1;
      end else begin
        if (!(&stat_other)) stat_other <= stat_other + 1'b1;
      end
    end
  end
`else
  assign stat_pass  = '0;
  assign stat_fail  = '0;
  assign stat_other = '0;
`endif

endmodule

// File: tb/tb_mtc_pkt_receiver.sv
// Scoreboard bench for mtc_pkt_receiver (N_IN=3, DROP_CNT_W=4).
// Directed vectors; a negedge monitor checks every output handshake.
module tb_mtc_pkt_receiver;

  logic        clock = 1'b0;
  logic        rst;
  logic [47:0] mtc_in [3];
  logic        out_valid;
  logic        out_ready;
  logic [46:0] out_pkt;
  logic [26:0] out_common;
  logic [3:0]  out_procflags;
  logic [1:0]  out_lane;
  logic [3:0]  drop_cnt [3];
  logic        stats_clr;
  logic [31:0] stat_pass;
  logic [31:0] stat_fail;
  logic [31:0] stat_other;

  always #5 clock = ~clock;

  mtc_pkt_receiver #(
    .N_IN(3), .DROP_CNT_W(4), .STAT_CNT_W(32)
  ) dut (
    .clock(clock), .rst(rst), .mtc_in(mtc_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pkt(out_pkt), .out_common(out_common),
    .out_procflags(out_procflags), .out_lane(out_lane),
    .drop_cnt(drop_cnt), .stats_clr(stats_clr),
    .stat_pass(stat_pass), .stat_fail(stat_fail),
    .stat_other(stat_other)
  );

  typedef struct packed {
    logic [1:0]  lane;
    logic [47:0] w;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int m_pass = 0;
  int m_fail = 0;
  int m_other = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [47:0] mkw(int lane, int seq, logic [3:0] pf);
    logic [47:0] w;
    logic [22:0] s;
    w = '0;
    s = 23'(seq * 37 + 5);
    w[47] = 1'b1;
    w[46:20] = {lane[3:0], s};
    w[11:4] = seq[7:0];
    w[3:0] = pf;
    return w;
  endfunction

  function automatic logic [63:0] st(int v);
`ifdef MTC_RX_PROCFLAG_STATS_EN
    return 64'(v);
`else
    return 64'(v * 0);
`endif
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 64'(out_pkt), 64'h0);
      end else begin
        e = q.pop_front();
        chk("out_pkt", 64'(out_pkt), 64'(e.w[46:0]));
        chk("out_lane", 64'(out_lane), 64'(e.lane));
        chk("out_common", 64'(out_common), 64'(e.w[46:20]));
        chk("out_procflags", 64'(out_procflags), 64'(e.w[3:0]));
        if (e.w[3:0] == 4'd1) m_pass++;
        else if (e.w[3:0] == 4'd2) m_fail++;
        else m_other++;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_in();
    for (int i = 0; i < 3; i++) mtc_in[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_in();
    out_ready = 1'b0;
    stats_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
    m_pass = 0;
    m_fail = 0;
    m_other = 0;
  endtask

  task automatic expect_pkt(int lane, logic [47:0] w);
    exp_t e;
    e.lane = 2'(lane);
    e.w = w;
    q.push_back(e);
  endtask

  task automatic drain(string nm);
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    chk(nm, 64'(q.size()), 64'd0);
    step();
  endtask

  task automatic chk_stats(string nm);
    chk({nm, "_pass"}, 64'(stat_pass), st(m_pass));
    chk({nm, "_fail"}, 64'(stat_fail), st(m_fail));
    chk({nm, "_other"}, 64'(stat_other), st(m_other));
  endtask

  logic [47:0] w0;

  initial begin
    do_reset();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pkt", 64'(out_pkt), 64'd0);
    chk("rst_lane", 64'(out_lane), 64'd0);
    chk("rst_pf", 64'(out_procflags), 64'd0);
    for (int i = 0; i < 3; i++)
      chk("rst_drop", 64'(drop_cnt[i]), 64'd0);
    chk_stats("rst_stat");

    // single packet on lane 1
    out_ready = 1'b1;
    w0 = mkw(1, 1, 4'd1);
    mtc_in[1] = w0;
    expect_pkt(1, w0);
    step();
    clr_in();
    chk("lat_t", 64'(out_valid), 64'd0);
    step();
    chk("lat_t1", 64'(out_valid), 64'd1);
    chk("lat_lane", 64'(out_lane), 64'd1);
    step();
    chk_stats("single");

    // all-zero payload is still a packet
    w0 = 48'h8000_0000_0000;
    mtc_in[0] = w0;
    expect_pkt(0, w0);
    step();
    clr_in();
    drain("zero_drain");
    chk_stats("zero");

    // fairness
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      for (int l = 0; l < 3; l++) begin
        w0 = mkw(l, 10 + c, 4'(l));
        mtc_in[l] = w0;
      end
      step();
    end
    clr_in();
    for (int c = 0; c < 2; c++)
      for (int l = 0; l < 3; l++)
        expect_pkt(l, mkw(l, 10 + c, 4'(l)));
    drain("fair_drain");
    for (int i = 0; i < 3; i++)
      chk("fair_drop", 64'(drop_cnt[i]), 64'd0);
    chk_stats("fair");

    // backpressure
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mtc_in[0] = mkw(0, 20 + i, 4'd1);
      step();
      if (i >= 1) begin
        w0 = mkw(0, 20, 4'd1);
        chk("bp_stable", 64'(out_pkt), 64'(w0[46:0]));
      end
    end
    clr_in();
    chk("bp_drop", 64'(drop_cnt[0]), 64'd7);
    for (int i = 0; i < 3; i++)
      expect_pkt(0, mkw(0, 20 + i, 4'd1));
    out_ready = 1'b1;
    drain("bp_drain");

    // push and pop on a full buffer
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mtc_in[0] = mkw(0, 40 + i, 4'(i));
      expect_pkt(0, mkw(0, 40 + i, 4'(i)));
      step();
    end
    out_ready = 1'b1;
    mtc_in[0] = mkw(0, 43, 4'd4);
    expect_pkt(0, mkw(0, 43, 4'd4));
    step();
    clr_in();
    drain("pp_drain");
    chk("pp_drop", 64'(drop_cnt[0]), 64'd0);
    chk_stats("pp");

    // reset mid-burst
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mtc_in[1] = mkw(1, 50 + i, 4'd1);
      mtc_in[2] = mkw(2, 50 + i, 4'd2);
      step();
    end
    clr_in();
    chk("mb_drop2", 64'(drop_cnt[2]), 64'd1);
    rst = 1'b1;
    step();
    chk("mb_valid", 64'(out_valid), 64'd0);
    chk("mb_drop_clr", 64'(drop_cnt[2]), 64'd0);
    rst = 1'b0;
    m_pass = 0;
    m_fail = 0;
    m_other = 0;
    out_ready = 1'b1;
    mtc_in[0] = mkw(0, 60, 4'd2);
    mtc_in[2] = mkw(2, 60, 4'd1);
    expect_pkt(0, mkw(0, 60, 4'd2));
    expect_pkt(2, mkw(2, 60, 4'd1));
    step();
    clr_in();
    drain("mb_drain");
    chk_stats("mb");

    // drop saturation then stats_clr
    out_ready = 1'b0;
    for (int i = 0; i < 23; i++) begin
      mtc_in[0] = mkw(0, 70 + i, 4'd0);
      step();
    end
    clr_in();
    chk("sat_drop", 64'(drop_cnt[0]), 64'd15);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    m_pass = 0;
    m_fail = 0;
    m_other = 0;
    chk("clr_drop", 64'(drop_cnt[0]), 64'd0);
    chk_stats("clr");

    do_reset();
    chk("end_q", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
